// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and bit-timing helper
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Whole system clocks per serial bit, rounded down.
    function automatic int cycles_per_bit(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through byte buffer
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overrun
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_data = mem_q[rd_ptr_q];
    assign overrun  = overrun_q;

    // A push into a full buffer still succeeds when the head leaves in the same cycle.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        overrun_d = push && full && !do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Buffer state registers; reset flushes contents so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 UART receiver with framing check and byte buffer
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 200,
    parameter int BAUD_RATE = 115200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   rx_busy
);

    localparam int CPB   = cycles_per_bit(CLK_FRE, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    logic                   sync1_q, sync2_q, sync3_q;
    logic [2:0]             vld_q;
    logic                   rx_s, fall_edge;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   push;
    logic                   fifo_full, fifo_empty;

    assign rx_s = sync2_q;
    // vld_q marks which sync stages hold real pin samples, so the reset value
    // of the chain can never look like a start edge on a line held low.
    assign fall_edge = vld_q[2] && sync3_q && !rx_s;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign rx_valid  = !fifo_empty;

    // Metastability synchroniser plus edge-detect register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            vld_q   <= '0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            vld_q   <= {vld_q[1:0], 1'b1};
        end
    end

    // Receive FSM: start validation at half-bit, then full-bit strides to mid-bit samples.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters and shift register state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH(UART_DATA_W),
        .DEPTH(UART_RX_FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(shift_q),
        .pop      (rx_valid && rx_ready),
        .pop_data (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame
module tb_uart_rx_frame;

    // 32 MHz / 1 Mbaud: CPB = 32, HALF = 16, start-edge to rx_valid = 2+16+9*32+1 = 307
    localparam int CPB  = 32;
    localparam int HALF = 16;
    localparam int LAT  = 307;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int ferr_cyc = -1;
    int vrise_cyc = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q [$];

    uart_rx_frame #(
        .CLK_FRE  (32),
        .BAUD_RATE(1000000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every handshake pops the scoreboard; pulses are tallied.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
                end else begin
                    check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                ferr_cyc = cyc;
            end
            if (overrun) ovr_cnt++;
            if (rx_valid && !prev_valid) vrise_cyc = cyc;
        end
        prev_valid = rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller sits 1 time unit after a posedge; each bit lasts CPB cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        t0 = cyc;
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CPB);
        end
        uart_rx = stop_bit;
        idle(CPB);
    endtask

    initial begin
        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        idle(4);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        rst_n = 1'b1;
        idle(8);

        // Single good byte and its latency
        rx_ready = 1'b1;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        idle(4);
        check_range("latency_a3", vrise_cyc - t0, LAT - 2, LAT + 2);
        check("ferr_after_a3", ferr_cnt, 0);
        check("queue_after_a3", exp_q.size(), 0);

        // Framing error followed by a break, then a good byte
        send_frame(8'hA3, 1'b0);
        check("ferr_latency", ferr_cyc - t0, LAT);
        idle(2 * CPB);
        uart_rx = 1'b1;
        idle(2 * CPB);
        check("ferr_count", ferr_cnt, 1);
        check("busy_after_break", int'(rx_busy), 0);
        exp_q.push_back(8'h5C);
        send_frame(8'h5C, 1'b1);
        idle(4);
        check("queue_after_5c", exp_q.size(), 0);

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        idle(HALF / 2);
        uart_rx = 1'b1;
        idle(2 * CPB);
        check("glitch_busy", int'(rx_busy), 0);
        check("glitch_valid", int'(rx_valid), 0);
        check("glitch_ferr", ferr_cnt, 1);

        // Overrun: five back-to-back frames into a stalled consumer
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        idle(4);
        check("overrun_count", ovr_cnt, 1);
        check("valid_when_full", int'(rx_valid), 1);
        check("head_when_full", int'(rx_data), 1);
        rx_ready = 1'b1;
        idle(8);
        check("queue_after_drain", exp_q.size(), 0);
        check("valid_after_drain", int'(rx_valid), 0);

        // Pop coinciding with the fifth push: no overrun
        rx_ready = 1'b0;
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h18);
        exp_q.push_back(8'hE7);
        send_frame(8'h21, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h84, 1'b1);
        send_frame(8'h18, 1'b1);
        fork
            send_frame(8'hE7, 1'b1);
            begin
                idle(LAT - 1);
                rx_ready = 1'b1;
            end
        join
        idle(8);
        check("overrun_coincident", ovr_cnt, 1);
        check("queue_after_coincident", exp_q.size(), 0);
        check("valid_after_coincident", int'(rx_valid), 0);

        // Reset during data bit 4 of 0xFF, then a clean byte
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(5 * CPB + HALF);
                rst_n = 1'b0;
                idle(4);
                rst_n = 1'b1;
                check("valid_after_reset", int'(rx_valid), 0);
                check("busy_after_reset", int'(rx_busy), 0);
            end
        join
        idle(2 * CPB);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(8);
        check("queue_after_3c", exp_q.size(), 0);
        check("ferr_final", ferr_cnt, 1);
        check("overrun_final", ovr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1);
    end

endmodule
